// File: rtl/dut_sum_acc_if.sv
// Operand/result bundle for dut_sum_acc: operand pair in, running-sum FIFO head out.
// Handshake: a beat moves on a rising edge where valid && ready. Once raised, valid holds its payload until that edge. ready never depends combinationally on the same side's valid.
interface dut_sum_acc_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 clear_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [ACC_WIDTH-1:0] sum_o;
    logic                 ovf_o;
    logic [15:0]          count_o;

    modport slave (
        input  clear_i, in_valid_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, ovf_o, count_o
    );

    modport master (
        output clear_i, in_valid_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, ovf_o, count_o
    );
endinterface

// File: rtl/dut_sum_acc.sv
// Accumulates a_i + b_i into a running sum with wrap or saturate overflow handling.
// Each accepted pair pushes {sum, sticky overflow} into a DEPTH-entry result FIFO.
module dut_sum_acc #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int SATURATE  = 0
) (
    input  logic         clk,
    input  logic         rst,
    dut_sum_acc_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    if (ACC_WIDTH < WIDTH + 1) begin : g_bad_acc_width
        $fatal(1, "dut_sum_acc: ACC_WIDTH must be at least WIDTH+1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "dut_sum_acc: DEPTH must be a power of two and at least 2");
    end

    logic                 r_rst_q;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic [15:0]          r_count;
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [ACC_WIDTH-1:0] r_mem_sum [DEPTH];
    logic                 r_mem_ovf [DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_pop;
    logic [WIDTH:0]       w_pair;
    logic [ACC_WIDTH:0]   w_base;
    logic [ACC_WIDTH:0]   w_raw;
    logic                 w_of;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_ovf_next;
    logic [15:0]          w_count_next;

    // Pointers carry one extra wrap bit so full and empty are told apart without a counter.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_in_ready = !r_rst_q && !w_full;
    assign w_accept   = bus.in_valid_i && w_in_ready;
    assign w_pop      = !w_empty && bus.out_ready_i;

    assign w_pair = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    assign w_base = bus.clear_i ? '0 : {1'b0, r_acc};
    assign w_raw  = w_base + {{(ACC_WIDTH - WIDTH){1'b0}}, w_pair};
    assign w_of   = w_raw[ACC_WIDTH];

    always_comb begin
        w_acc_next = w_raw[ACC_WIDTH-1:0];
        if (w_of && (SATURATE != 0)) begin
            w_acc_next = '1;
        end
    end

    // A clear in the accept cycle restarts the flag and count from the new pair alone.
    assign w_ovf_next   = (bus.clear_i ? 1'b0 : r_ovf) | w_of;
    assign w_count_next = (bus.clear_i ? 16'd0 : r_count) + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q  <= 1'b1;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_count  <= 16'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_rst_q <= 1'b0;
            if (w_accept) begin
                r_acc    <= w_acc_next;
                r_ovf    <= w_ovf_next;
                r_count  <= w_count_next;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else if (bus.clear_i) begin
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_count <= 16'd0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the head outputs are gated by the occupancy flags.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem_sum[r_wr_ptr[AW-1:0]] <= w_acc_next;
            r_mem_ovf[r_wr_ptr[AW-1:0]] <= w_ovf_next;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = !w_empty;
    assign bus.sum_o       = w_empty ? '0 : r_mem_sum[r_rd_ptr[AW-1:0]];
    assign bus.ovf_o       = w_empty ? 1'b0 : r_mem_ovf[r_rd_ptr[AW-1:0]];
    assign bus.count_o     = r_count;
endmodule
